// File: rtl/bream_ascii_pkg.sv
// Shared constants, FSM state encoding and power-of-ten helper for the
// ASCII number streaming blocks.
package bream_ascii_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Largest power of ten the helper can produce in 64 bits.
  localparam int POW10_MAX_EXP = 19;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DIGIT  = 3'd1,
    EMIT   = 3'd2,
    DELIM1 = 3'd3,
    DELIM2 = 3'd4
  } state_t;

  // 10**idx as a 64-bit constant; callers truncate to N_WIDTH+1 bits.
  // The loop bound is constant so the whole thing folds into a lookup.
  function automatic logic [63:0] pow10(input int idx);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < POW10_MAX_EXP; i++) begin
      if (i < idx) p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/dec16_ascii_streamer_digit.sv
// dec_digit_sub: holds the running remainder and the current digit count,
// doing one compare/subtract against 10**idx per enabled cycle.
module dec_digit_sub
  import bream_ascii_pkg::*;
#(
  parameter int N_WIDTH = 16,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic               clr_cnt,
  input  logic               seen,
  input  logic [N_WIDTH-1:0] n,
  input  logic [IDX_W-1:0]   idx,
  output logic               digit_done,
  output logic               digit_skip,
  output logic [3:0]         digit_val
);

  logic [N_WIDTH-1:0] rem;
  logic [3:0]         cnt;
  logic [N_WIDTH:0]   pow;
  logic               ge;
  logic               emit_ok;

  // One extra bit on the power so the top power can exceed the largest rem.
  assign pow = (N_WIDTH + 1)'(pow10(int'(idx)));
  assign ge  = ({1'b0, rem} >= pow);

  // A zero count is only printed once a non-zero digit has been seen,
  // or when it is the units digit (so n=0 still prints "0").
  assign emit_ok    = (cnt != 4'd0) || seen || (idx == '0);
  assign digit_done = en && !ge && emit_ok;
  assign digit_skip = en && !ge && !emit_ok;
  assign digit_val  = cnt;

  // Remainder/count register: load on start, subtract while rem >= 10**idx.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem <= '0;
      cnt <= '0;
    end else if (load) begin
      rem <= n;
      cnt <= '0;
    end else if (clr_cnt) begin
      cnt <= '0;
    end else if (en && ge) begin
      rem <= rem - pow[N_WIDTH-1:0];
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dec16_ascii_streamer.sv
// dec16_ascii_streamer: prints an unsigned number as ASCII decimal digits
// followed by two delimiter bytes over a valid/ready byte stream.
// Optional macro DEC_ZERO_PAD_EN: when defined, leading zeros are kept and
// exactly N_DIGITS digits are always emitted.
module dec16_ascii_streamer
  import bream_ascii_pkg::*;
#(
  parameter int N_WIDTH  = 16,
  parameter int N_DIGITS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_WIDTH-1:0] n,
  input  logic [7:0]         delim1byte,
  input  logic [7:0]         delim2byte,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               result_ready
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N_DIGITS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             seen_q, seen_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic [7:0]       delim1_q, delim1_d;
  logic [7:0]       delim2_q, delim2_d;

  logic       load;
  logic       clr_cnt;
  logic       xfer;
  logic       seen_eff;
  logic       digit_done;
  logic       digit_skip;
  logic [3:0] digit_val;

`ifdef DEC_ZERO_PAD_EN
  assign seen_eff = 1'b1;
`else
  assign seen_eff = seen_q;
`endif

  assign xfer         = valid_q && byte_ready;
  assign byte_out     = byte_q;
  assign byte_valid   = valid_q;
  assign result_ready = (state_q == IDLE) && !start;

  dec_digit_sub #(
    .N_WIDTH (N_WIDTH),
    .IDX_W   (IDX_W)
  ) u_digit (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .en         (state_q == DIGIT),
    .clr_cnt    (clr_cnt),
    .seen       (seen_eff),
    .n          (n),
    .idx        (idx_q),
    .digit_done (digit_done),
    .digit_skip (digit_skip),
    .digit_val  (digit_val)
  );

  // State and stream registers; reset abandons any partial output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      seen_q   <= 1'b0;
      byte_q   <= 8'h00;
      valid_q  <= 1'b0;
      delim1_q <= 8'h00;
      delim2_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      seen_q   <= seen_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      delim1_q <= delim1_d;
      delim2_q <= delim2_d;
    end
  end

  // Next-state logic: walk digit positions, then hold each byte until taken.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    seen_d   = seen_q;
    byte_d   = byte_q;
    valid_d  = valid_q;
    delim1_d = delim1_q;
    delim2_d = delim2_q;
    load     = 1'b0;
    clr_cnt  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          delim1_d = delim1byte;
          delim2_d = delim2byte;
          idx_d    = IDX_TOP;
          seen_d   = 1'b0;
          state_d  = DIGIT;
        end
      end
      DIGIT: begin
        if (digit_done) begin
          byte_d  = ASCII_ZERO + {4'b0000, digit_val};
          valid_d = 1'b1;
          seen_d  = 1'b1;
          state_d = EMIT;
        end else if (digit_skip) begin
          idx_d   = idx_q - IDX_W'(1);
          clr_cnt = 1'b1;
        end
      end
      EMIT: begin
        if (xfer) begin
          if (idx_q == '0) begin
            byte_d  = delim1_q;
            state_d = DELIM1;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            clr_cnt = 1'b1;
            valid_d = 1'b0;
            state_d = DIGIT;
          end
        end
      end
      DELIM1: begin
        if (xfer) begin
          byte_d  = delim2_q;
          state_d = DELIM2;
        end
      end
      DELIM2: begin
        if (xfer) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dec16_ascii_streamer.sv
// Testbench for dec16_ascii_streamer: directed and randomized numbers checked
// against a decimal-formatting reference model, with optional backpressure.
module tb_dec16_ascii_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] n;
  logic [7:0]  delim1byte;
  logic [7:0]  delim2byte;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        result_ready;

  int passCount  = 0;
  int checkCount = 0;
  logic [7:0] expQ[$];

  dec16_ascii_streamer #(
    .N_WIDTH  (16),
    .N_DIGITS (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .n            (n),
    .delim1byte   (delim1byte),
    .delim2byte   (delim2byte),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .result_ready (result_ready)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Reference model: decimal digits of the value plus both delimiters.
  function automatic void buildExpected(input int unsigned value, input logic [7:0] d1, input logic [7:0] d2);
    int unsigned v = value;
    int unsigned digs[$];
    expQ.delete();
    do begin
      digs.push_front(v % 10);
      v = v / 10;
    end while (v != 0);
`ifdef DEC_ZERO_PAD_EN
    while (digs.size() < 5) digs.push_front(0);
`endif
    foreach (digs[i]) expQ.push_back(8'(32'h30 + digs[i]));
    expQ.push_back(d1);
    expQ.push_back(d2);
  endfunction

  // One full conversion. mode 0: ready always high, 1: random ready,
  // 2: ready held low for 5 cycles once the first byte is valid.
  // glitch pulses start (with n=9) while busy; it must be ignored.
  task automatic applyStimulus(input logic [15:0] value, input logic [7:0] d1, input logic [7:0] d2,
                               input int mode, input bit glitch);
    int         cycles  = 0;
    int         stall   = 5;
    bit         pending = 0;
    logic [7:0] heldByte = 8'h00;
    buildExpected(value, d1, d2);
    @(negedge clk);
    n          = value;
    delim1byte = d1;
    delim2byte = d2;
    start      = 1'b1;
    byte_ready = 1'b0;
    #1 checkOutput("rr_during_start", result_ready, 0);
    @(negedge clk);
    start      = 1'b0;
    n          = 16'($urandom);
    delim1byte = 8'($urandom);
    delim2byte = 8'($urandom);
    while (expQ.size() > 0 && cycles < 400) begin
      start = glitch && expQ.size() > 3 && (cycles == 1 || $urandom_range(0, 3) == 0);
      if (start) n = 16'd9;
      case (mode)
        0: byte_ready = 1'b1;
        1: byte_ready = 1'($urandom_range(0, 1));
        default: begin
          if (byte_valid && stall > 0) begin
            byte_ready = 1'b0;
            stall--;
          end else byte_ready = 1'b1;
        end
      endcase
      if (pending) begin
        checkOutput("valid_hold", byte_valid, 1);
        checkOutput("data_hold", byte_out, heldByte);
      end
      if (byte_valid && byte_ready) begin
        checkOutput("byte", byte_out, expQ.pop_front());
        pending = 0;
      end else begin
        pending  = byte_valid;
        heldByte = byte_out;
      end
      cycles++;
      if (expQ.size() > 0) @(negedge clk);
    end
    checkOutput("bytes_remaining", expQ.size(), 0);
    start = 1'b0;
    @(negedge clk);
    byte_ready = 1'b0;
    #1;
    checkOutput("end_valid", byte_valid, 0);
    checkOutput("end_result_ready", result_ready, 1);
  endtask

  // Reset asserted while the first delimiter is being offered.
  task automatic resetInDelim1();
    int c = 0;
    buildExpected(5, 8'h0D, 8'h0A);
    @(negedge clk);
    n = 16'd5; delim1byte = 8'h0D; delim2byte = 8'h0A;
    start = 1'b1; byte_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (expQ.size() > 2 && c < 200) begin
      byte_ready = 1'b1;
      if (byte_valid) checkOutput("rst_digit", byte_out, expQ.pop_front());
      if (expQ.size() > 2) @(negedge clk);
      c++;
    end
    checkOutput("rst_digits_left", expQ.size(), 2);
    @(negedge clk);
    byte_ready = 1'b0;
    #1;
    checkOutput("rst_pre_valid", byte_valid, 1);
    checkOutput("rst_pre_delim1", byte_out, expQ[0]);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", byte_valid, 0);
    checkOutput("rst_byte", byte_out, 8'h00);
    checkOutput("rst_result_ready", result_ready, 1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; n = '0;
    delim1byte = 8'h0D; delim2byte = 8'h0A; byte_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", byte_valid, 0);
    checkOutput("reset_byte", byte_out, 8'h00);
    checkOutput("reset_result_ready", result_ready, 1);
    rst_n = 1'b1;

    applyStimulus(16'd0,     8'h0D, 8'h0A, 0, 0);
    applyStimulus(16'd65535, 8'h0D, 8'h0A, 0, 0);
    applyStimulus(16'd1000,  8'h0D, 8'h0A, 0, 0);
    applyStimulus(16'd7,     8'h0D, 8'h0A, 2, 0);
    applyStimulus(16'd123,   8'h0D, 8'h0A, 0, 1);
    applyStimulus(16'd42,    8'h0D, 8'h0A, 1, 0);
    resetInDelim1();
    applyStimulus(16'd10,    8'h2C, 8'h20, 0, 0);

    for (int i = 0; i < 25; i++) begin
      logic [15:0] v;
      v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 99)) : 16'($urandom_range(0, 65535));
      applyStimulus(v, 8'($urandom), 8'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
